// File: rtl/najla_ln_arbiter.sv
// Round-robin share of one in-order ln/log10 unit across NREQ requesters; zero added latency, head-of-line blocking on rsp_ready.
// NAJLA_LN_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module najla_ln_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*128-1:0]      req_x_q64,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic signed [63:0]       rsp_ln_q30,
  output logic signed [63:0]       rsp_log10_q30,
  output logic                     u_in_valid,
  input  logic                     u_in_ready,
  output logic [127:0]             u_in_x_q64,
  input  logic                     u_out_valid,
  output logic                     u_out_ready,
  input  logic signed [63:0]       u_out_ln_q30,
  input  logic signed [63:0]       u_out_log10_q30,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     err_orphan
);

  localparam int IW  = $clog2(NREQ);
  localparam int CIW = IW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t          state;
  logic [IW-1:0]   tag_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic            win_found;
  logic [CIW-1:0]  cand;
  logic [IW-1:0]   head;
  logic            empty;
  logic            can_issue;
  logic            fire;
  logic            pop;

  // Cyclic search starting at rr_ptr; with rr_ptr pinned at 0 this is plain fixed priority.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + CIW'(k);
      if (cand >= CIW'(NREQ)) cand = cand - CIW'(NREQ);
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win       = cand[IW-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign can_issue  = (state == RUN) && !drain_req && (count < CW'(DEPTH));
  assign u_in_valid = can_issue && (|req_valid);
  assign u_in_x_q64 = win_found ? req_x_q64[128*win +: 128] : 128'd0;
  assign fire       = u_in_valid && u_in_ready;

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[win] = 1'b1;
  end

  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  always_comb begin
    rsp_valid = '0;
    if (u_out_valid && !empty) rsp_valid[head] = 1'b1;
  end

  // With no tag outstanding any result is an orphan and is swallowed.
  assign u_out_ready   = empty ? u_out_valid : rsp_ready[head];
  assign pop           = u_out_valid && u_out_ready && !empty;
  assign rsp_ln_q30    = u_out_ln_q30;
  assign rsp_log10_q30 = u_out_log10_q30;
  assign count_next    = count + CW'(fire) - CW'(pop);

  always_ff @(posedge clk) begin
    if (fire) tag_mem[wr_ptr] <= win;
  end

`ifdef NAJLA_LN_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (u_out_valid && empty) err_orphan <= 1'b1;
    end
  end

  // Emptiness is judged on post-update occupancy so drain_done follows the last pop by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_req) begin
            if (count_next == '0) begin
              state      <= DRAINED;
              drain_done <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!drain_req) begin
            state <= RUN;
          end else if (count_next == '0) begin
            state      <= DRAINED;
            drain_done <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_najla_ln_arbiter.sv
// Bench for najla_ln_arbiter: fixed-latency unit model, grant model and in-order result scoreboard.
module tb_najla_ln_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_x;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_rdy;
  logic signed [63:0]   rsp_ln_q30;
  logic signed [63:0]   rsp_log10_q30;
  logic                 u_in_valid;
  logic                 u_in_ready;
  logic [127:0]         u_in_x_q64;
  logic                 u_out_valid;
  logic                 u_out_ready;
  logic signed [63:0]   u_out_ln_q30;
  logic signed [63:0]   u_out_log10_q30;
  logic                 drain_req;
  logic                 drain_done;
  logic                 err_orphan;
  logic                 orphan_frc;

  najla_ln_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x_q64(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy),
    .rsp_ln_q30(rsp_ln_q30), .rsp_log10_q30(rsp_log10_q30),
    .u_in_valid(u_in_valid), .u_in_ready(u_in_ready), .u_in_x_q64(u_in_x_q64),
    .u_out_valid(u_out_valid), .u_out_ready(u_out_ready),
    .u_out_ln_q30(u_out_ln_q30), .u_out_log10_q30(u_out_log10_q30),
    .drain_req(drain_req), .drain_done(drain_done), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rem [NREQ];
  int seq [NREQ];
  int fires [NREQ];
  int last_pop_cyc = -1;
  int m_rr = 0;
  logic [NREQ-1:0] fmask;

  typedef struct {
    int          id;
    logic [63:0] ln;
    logic [63:0] lg;
  } exp_t;
  exp_t sbq [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ln_f(input logic [127:0] x);
    return (x[63:0] ^ 64'h0123_4567_89ab_cdef) + x[127:64];
  endfunction

  function automatic logic [63:0] lg_f(input logic [127:0] x);
    return (x[127:64] * 64'd1000) + x[63:0];
  endfunction

  function automatic logic [127:0] stim_x(input int i, input int s);
    return {64'(i), 64'(s)};
  endfunction

  // Unit model: unbounded in-order queue, each result valid LAT cycles after acceptance.
  logic [127:0] um_x [16];
  int           um_rat [16];
  int           um_wp, um_rp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      um_wp <= 0;
      um_rp <= 0;
    end else begin
      if (u_in_valid && u_in_ready) begin
        um_x[um_wp % 16]   <= u_in_x_q64;
        um_rat[um_wp % 16] <= cyc + LAT;
        um_wp              <= um_wp + 1;
      end
      if (u_out_valid && u_out_ready && (um_wp != um_rp)) um_rp <= um_rp + 1;
    end
  end

  always_comb begin
    u_out_valid     = orphan_frc || ((um_wp != um_rp) && (cyc >= um_rat[um_rp % 16]));
    u_out_ln_q30    = ln_f(um_x[um_rp % 16]);
    u_out_log10_q30 = lg_f(um_x[um_rp % 16]);
  end

  // Monitor: grant model pushes expectations on issue; deliveries pop and compare.
  always @(negedge clk) begin
    int w;
    int idx;
    exp_t e;
    logic [NREQ-1:0] oh;
    logic [127:0] xs;
    if (!rst_n) begin
      fmask = '0;
      sbq.delete();
      m_rr = 0;
    end else begin
      fmask = req_valid & req_ready;
      if (u_in_valid && u_in_ready) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
        if (w < 0) begin
          chk("grant_without_request", 1, 0);
        end else begin
          oh = '0;
          oh[w] = 1'b1;
          xs = stim_x(w, seq[w]);
          chk("grant", req_ready, oh);
          chk("u_in_x", u_in_x_q64, xs);
          e.id = w;
          e.ln = ln_f(xs);
          e.lg = lg_f(xs);
          sbq.push_back(e);
          fires[w]++;
`ifdef NAJLA_LN_ARB_FIXED_PRIO_EN
          m_rr = 0;
`else
          m_rr = (w + 1) % NREQ;
`endif
        end
      end
      if (u_out_valid && u_out_ready && !orphan_frc) last_pop_cyc = cyc;
      if ((rsp_valid & rsp_rdy) != '0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sbq.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          chk("rsp_id", rsp_valid, oh);
          chk("rsp_ln", rsp_ln_q30, e.ln);
          chk("rsp_log10", rsp_log10_q30, e.lg);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (fmask[i]) begin
        rem[i]--;
        seq[i]++;
      end
      req_valid[i] = (rem[i] > 0);
      req_x[128*i +: 128] = stim_x(i, seq[i]);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic int rem_sum();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += rem[i];
    return s;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      tick();
      at_neg();
      n++;
      busy = (rem_sum() != 0) || (sbq.size() != 0);
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int f0 [NREQ];
    int w;
    logic [63:0] hold_ln;
    bit seen;

    rst_n = 1'b0; req_valid = '0; req_x = '0; rsp_rdy = '1;
    u_in_ready = 1'b1; drain_req = 1'b0; orphan_frc = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = 1; fires[i] = 0; end
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_u_in_valid", u_in_valid, 0);
    chk("rst_u_out_ready", u_out_ready, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_u_in_x", u_in_x_q64, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester, three back-to-back issues.
    rem[2] = 3;
    tick();
    at_neg();
    chk("single_first_fire", req_ready, 4'b0100);
    for (int d = 1; d <= 9; d++) begin
      tick();
      at_neg();
      chk($sformatf("single_rsp_d%0d", d), rsp_valid, (d >= LAT && d <= LAT + 2) ? 4'b0100 : 4'b0000);
    end
    wait_idle(50);

    // Fairness: all requesters continuously valid.
    for (int i = 0; i < NREQ; i++) begin f0[i] = fires[i]; rem[i] = 8; end
    wait_idle(500);
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_cnt%0d", i), fires[i] - f0[i], 8);

    // Full tag FIFO with every result stalled.
    tick();
    rsp_rdy = '0;
    rem[1] = 20;
    f0[1] = fires[1];
    repeat (30) tick();
    at_neg();
    chk("full_fires", fires[1] - f0[1], DEPTH);
    chk("full_u_in_valid", u_in_valid, 0);
    tick();
    rsp_rdy = 4'b0010;
    at_neg();
    chk("full_release_pop", u_out_ready, 1);
    tick();
    rsp_rdy = '0;
    at_neg();
    chk("full_refill_fire", u_in_valid, 1);
    repeat (10) tick();
    at_neg();
    chk("full_one_more", fires[1] - f0[1], DEPTH + 1);
    tick();
    rsp_rdy = '1;
    wait_idle(200);

    // Head requester 1 stalls; 2 and 3 queue behind it.
    tick();
    rsp_rdy = 4'b1101;
    rem[1] = 1;
    tick();
    rem[2] = 1;
    rem[3] = 1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      at_neg();
      seen = (rsp_valid != '0);
    end
    if (!seen) chk("bp_wait_timeout", 1, 0);
    hold_ln = rsp_ln_q30;
    for (int j = 0; j < 5; j++) begin
      chk("bp_u_out_ready", u_out_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_ln_stable", rsp_ln_q30, hold_ln);
      tick();
      at_neg();
    end
    tick();
    rsp_rdy = '1;
    wait_idle(100);

    // Drain with 5 in flight and a pending request.
    tick();
    rsp_rdy = '0;
    rem[0] = 5;
    f0[0] = fires[0];
    repeat (10) tick();
    at_neg();
    chk("drain_inflight", fires[0] - f0[0], 5);
    f0[3] = fires[3];
    rem[3] = 4;
    tick();
    drain_req = 1'b1;
    at_neg();
    chk("drain_block_same_cycle", u_in_valid, 0);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (n == 0) rsp_rdy = '1;
      at_neg();
      seen = drain_done;
    end
    chk("drain_done_seen", drain_done, 1);
    chk("drain_done_timing", cyc, last_pop_cyc + 1);
    chk("drain_no_grants", fires[3] - f0[3], 0);
    chk("drain_sb_empty", sbq.size(), 0);
    tick();
    drain_req = 1'b0;
    at_neg();
    chk("undrain_hold", u_in_valid, 0);
    chk("undrain_done_hold", drain_done, 1);
    tick();
    at_neg();
    chk("undrain_resume", req_ready, 4'b1000);
    chk("undrain_done_clr", drain_done, 0);
    wait_idle(100);

    // Drain requested while already empty.
    tick();
    drain_req = 1'b1;
    at_neg();
    chk("drain_empty_same", drain_done, 0);
    tick();
    at_neg();
    chk("drain_empty_next", drain_done, 1);
    tick();
    drain_req = 1'b0;
    tick();

    // Orphan result with an empty tag FIFO.
    tick();
    orphan_frc = 1'b1;
    at_neg();
    chk("orphan_discard", u_out_ready, 1);
    chk("orphan_not_yet", err_orphan, 0);
    tick();
    orphan_frc = 1'b0;
    at_neg();
    chk("orphan_set", err_orphan, 1);
    repeat (3) tick();
    at_neg();
    chk("orphan_sticky", err_orphan, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("orphan_reset", err_orphan, 0);
    chk("reset2_drain_done", drain_done, 0);
    chk("reset2_u_in_valid", u_in_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
